// File: rtl/mcycle_alu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer driving an external combinational ALU, one op per cycle.
// Optional: define MCYCLE_ZERO_SKIP_EN to let mul ops with a zero operand finish in two cycles.
module mcycle_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [2:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALU_Src_A,
  output logic [WIDTH-1:0] ALU_Src_B,
  output logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic [2:0]       ALU_Flags
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE, S_SHORT, S_PRE_A, S_PRE_B, S_ITER, S_POST_LO, S_POST_HI
  } state_t;

  state_t           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_reg, b_reg, p_hi, p_lo;
  logic [4:0]       count;
  logic             neg_a, neg_b, neg_res, lo_zero;

  // Flag decode: {eq, lt, ltu}; lt is never needed here.
  logic alu_eq, alu_ltu, unused_lt;
  assign alu_eq    = ALU_Flags[2];
  assign unused_lt = ALU_Flags[1];
  assign alu_ltu   = ALU_Flags[0];

  logic             is_div;
  logic [WIDTH-1:0] p_hi_shl;
  logic             div_q;
  assign is_div   = op[2];
  assign p_hi_shl = {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
  assign div_q    = p_hi[WIDTH-1] | ~alu_ltu;

  // Start-time decode of signedness, result sign and shortcut conditions.
  logic start_neg_a, start_neg_b, start_neg_res, div_zero, zero_skip;
  always_comb begin
    start_neg_a   = Operand1[WIDTH-1] & (MCycleOp[2] ? ~MCycleOp[0] : ~(MCycleOp[1] & MCycleOp[0]));
    start_neg_b   = Operand2[WIDTH-1] & (MCycleOp[2] ? ~MCycleOp[0] : ~MCycleOp[1]);
    start_neg_res = (MCycleOp[2] & MCycleOp[1]) ? start_neg_a : (start_neg_a ^ start_neg_b);
    div_zero      = MCycleOp[2] && (Operand2 == '0);
`ifdef MCYCLE_ZERO_SKIP_EN
    zero_skip     = !MCycleOp[2] && ((Operand1 == '0) || (Operand2 == '0));
`else
    zero_skip     = 1'b0;
`endif
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    ALU_Control = ALU_ADD;
    ALU_Src_A   = '0;
    ALU_Src_B   = '0;
    unique case (state)
      S_PRE_A: begin
        ALU_Control = neg_a ? ALU_SUB : ALU_ADD;
        ALU_Src_A   = neg_a ? '0 : a_reg;
        ALU_Src_B   = neg_a ? a_reg : '0;
      end
      S_PRE_B: begin
        ALU_Control = neg_b ? ALU_SUB : ALU_ADD;
        ALU_Src_A   = neg_b ? '0 : b_reg;
        ALU_Src_B   = neg_b ? b_reg : '0;
      end
      S_ITER: begin
        if (is_div) begin
          ALU_Control = ALU_SUB;
          ALU_Src_A   = p_hi_shl;
          ALU_Src_B   = b_reg;
        end else begin
          ALU_Control = ALU_ADD;
          ALU_Src_A   = p_hi;
          ALU_Src_B   = p_lo[0] ? a_reg : '0;
        end
      end
      S_POST_LO: begin
        ALU_Control = neg_res ? ALU_SUB : ALU_ADD;
        ALU_Src_A   = neg_res ? '0 : p_lo;
        ALU_Src_B   = neg_res ? p_lo : '0;
      end
      S_POST_HI: begin
        if (neg_res && !is_div) begin
          // Two's-complement of the 64-bit product: borrow into hi only when lo was zero.
          ALU_Control = lo_zero ? ALU_SUB : ALU_XOR;
          ALU_Src_A   = lo_zero ? '0 : p_hi;
          ALU_Src_B   = lo_zero ? p_hi : '1;
        end else if (neg_res && op[1]) begin
          ALU_Control = ALU_SUB;
          ALU_Src_A   = '0;
          ALU_Src_B   = p_hi;
        end else begin
          ALU_Src_A   = p_hi;
        end
      end
      default: ;
    endcase
  end

  // NOTE: all state, including the operand and product registers, is cleared by reset so an
  // aborted operation leaves nothing behind; sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_IDLE;
      op      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      count   <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      neg_res <= 1'b0;
      lo_zero <= 1'b0;
      Result  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: if (Start) begin
          op      <= MCycleOp;
          a_reg   <= Operand1;
          b_reg   <= Operand2;
          neg_a   <= start_neg_a;
          neg_b   <= start_neg_b;
          neg_res <= start_neg_res;
          p_hi    <= '0;
          p_lo    <= '0;
          Busy    <= 1'b1;
          state   <= (div_zero || zero_skip) ? S_SHORT : S_PRE_A;
        end
        S_SHORT: begin
          // Only divide-by-zero and zero-operand multiply land here.
          Result <= !is_div ? '0 : (op[1] ? a_reg : '1);
          Done   <= 1'b1;
          Busy   <= 1'b0;
          state  <= S_IDLE;
        end
        S_PRE_A: begin
          a_reg <= ALU_Result;
          state <= S_PRE_B;
        end
        S_PRE_B: begin
          b_reg <= ALU_Result;
          p_hi  <= '0;
          p_lo  <= is_div ? a_reg : ALU_Result;
          count <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            p_hi <= div_q ? ALU_Result : p_hi_shl;
            p_lo <= {p_lo[WIDTH-2:0], div_q};
          end else begin
            p_hi <= {~alu_ltu, ALU_Result[WIDTH-1:1]};
            p_lo <= {ALU_Result[0], p_lo[WIDTH-1:1]};
          end
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_POST_LO;
        end
        S_POST_LO: begin
          p_lo    <= ALU_Result;
          lo_zero <= alu_eq;
          state   <= S_POST_HI;
        end
        S_POST_HI: begin
          p_hi   <= ALU_Result;
          Result <= (op == 3'b000 || op[2:1] == 2'b10) ? p_lo : ALU_Result;
          Done   <= 1'b1;
          Busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_alu_sequencer.sv
// Directed bench for mcycle_alu_sequencer with a behavioural ALU model and a vector table.
module tb_mcycle_alu_sequencer;

`ifdef MCYCLE_ZERO_SKIP_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 37;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mcycle_op;
  logic [31:0] op1, op2, result, src_a, src_b, alu_res;
  logic        busy, done;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcycle_alu_sequencer #(.WIDTH(32)) dut (
    .CLK(clk), .RESETn(rst_n), .Start(start), .MCycleOp(mcycle_op),
    .Operand1(op1), .Operand2(op2), .Result(result), .Busy(busy), .Done(done),
    .ALU_Src_A(src_a), .ALU_Src_B(src_b), .ALU_Control(alu_ctrl),
    .ALU_Result(alu_res), .ALU_Flags(alu_flags)
  );

  // Behavioural ALU: flags {eq, lt, ltu}; after add ltu = ~carry, after sub ltu = A<B unsigned.
  always_comb begin
    logic [32:0] sum;
    sum       = '0;
    alu_res   = '0;
    alu_flags = '0;
    case (alu_ctrl)
      4'b0000: begin
        sum       = {1'b0, src_a} + {1'b0, src_b};
        alu_res   = sum[31:0];
        alu_flags = {sum[31:0] == 32'd0, 1'b0, ~sum[32]};
      end
      4'b0001: begin
        alu_res   = src_a - src_b;
        alu_flags = {src_a == src_b, $signed(src_a) < $signed(src_b), src_a < src_b};
      end
      4'b1000: begin
        alu_res   = src_a ^ src_b;
        alu_flags = {alu_res == 32'd0, 1'b0, 1'b0};
      end
      default: alu_res = 32'hDEADBEEF;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and follow it to Done; optionally re-pulse Start with other operands at repulse_cyc.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name,
                        input int repulse_cyc);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    mcycle_op = op; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == repulse_cyc) begin
        start = 1'b1; mcycle_op = 3'b101; op1 = 32'd100; op2 = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && cyc < 100);
    start = 1'b0;
    check({name, " latency"}, cyc, lat);
    check({name, " result"}, result, exp);
    check({name, " busy low at done"}, {31'd0, busy}, 32'd0);
    check({name, " busy held"}, {31'd0, busy_ok}, 32'd1);
    check({name, " idle alu"}, {alu_ctrl, 28'd0} | src_a | src_b, 32'd0);
    @(negedge clk);
    check({name, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 37, "mul 7*-3");
    add_vec(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 37, "mulh min*min");
    add_vec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 37, "mulhu max*max");
    add_vec(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 37, "mulhsu -1*2");
    add_vec(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 37, "mul -1*-1");
    add_vec(3'b001, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 37, "mulh lo-zero borrow");
    add_vec(3'b000, 32'hFFFF0000, 32'h00010000, 32'h00000000, 37, "mul lo-zero");
    add_vec(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 37, "div -7/2");
    add_vec(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 37, "rem -7/2");
    add_vec(3'b101, 32'd100,      32'd7,        32'd14,       37, "divu 100/7");
    add_vec(3'b111, 32'd100,      32'd7,        32'd2,        37, "remu 100/7");
    add_vec(3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 37, "div 100/-7");
    add_vec(3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        37, "rem 100/-7");
    add_vec(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  "div 5/0");
    add_vec(3'b111, 32'd5,        32'd0,        32'd5,        2,  "remu 5/0");
    add_vec(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 37, "div ovf");
    add_vec(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 37, "rem ovf");
    add_vec(3'b011, 32'd0,        32'h00001234, 32'h00000000, ZLAT, "mulhu 0*x");

    rst_n = 1'b0; start = 1'b0; mcycle_op = '0; op1 = '0; op2 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset alu drive", {alu_ctrl, 28'd0} | src_a | src_b, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 0);

    // Start re-pulsed mid-operation must be ignored.
    run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 37, "ignored restart", 5);

    // Asynchronous abort at cycle 10, then a fresh op.
    @(negedge clk);
    mcycle_op = 3'b000; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("busy before abort", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 37, "divu after abort", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcycle_alu_sequencer.md
Name: mcycle_alu_sequencer

Overview:
- Multi-cycle RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Computes iteratively by driving the existing combinational ALU port set (Src_A, Src_B, ALUControl in; ALUResult, ALUFlags out) as its initiator, one ALU op per cycle.
- Sits in Execute beside the ALU. The datapath muxes the ALU inputs to this block while Busy=1.

Parameters:
- WIDTH, 32, operand/result width; only 32 supported, so shift counter is 5 bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- Start  input  1  request pulse; sampled only in IDLE.
- MCycleOp  input  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- Operand1  input  32  rs1 (multiplicand/dividend); latched at Start.
- Operand2  input  32  rs2 (multiplier/divisor); latched at Start.
- Result  output  32  final result; held until next accepted Start.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when Result becomes valid.
- ALU_Src_A  output  32  to ALU Src_A.
- ALU_Src_B  output  32  to ALU Src_B.
- ALU_Control  output  4  to ALU; uses only 0000 add, 0001 sub, 1000 xor.
- ALU_Result  input  32  from ALU.
- ALU_Flags  input  3  from ALU, {eq, lt, ltu}. After add, carry-out = ~ltu. After sub, ltu = unsigned A<B.

Behaviour:
- Reset: state IDLE; Busy=0, Done=0, Result=0; internal registers cleared.
- Reset mid-operation aborts immediately, with the same values as reset. Reset has no other effect.
- IDLE drives ALU_Control=0000 and ALU_Src_A=ALU_Src_B=0.
- Start in IDLE (edge 0): latch operands and op.
  - Compute negA, negB, negRes from op signedness: mulhsu signs A only; div/rem sign both; rem result sign = dividend sign.
  - Set Busy=1 from cycle 1.
- Start while Busy=1 is ignored.
- Divide-by-zero (div ops, Operand2==0): go straight to DONE.
  - Done at cycle 2.
  - div/divu result 0xFFFFFFFF; rem/remu result = Operand1.
- Normal flow, fixed latency: PRE_A, PRE_B, ITER x32, POST_LO, POST_HI, DONE.
  - Busy is high for cycles 1..36.
  - Done pulses in cycle 37 with Busy=0 and the state back in IDLE.
- PRE_A / PRE_B: ALU sub 0-x if the negate flag is set, else add x+0; store magnitude.
- Registers: P_hi (32), P_lo (32), counter (5).
- Multiply, P_lo = |B|, P_hi = 0. Each ITER:
  - ALU add P_hi + (P_lo[0] ? |A| : 0).
  - {~ltu, ALU_Result, P_lo} >> 1 loads {P_hi, P_lo}.
- Divide, P_lo = |A|, P_hi = 0. Each ITER:
  - Shift {P_hi, P_lo} left 1; capture the bit out of P_hi as ovf.
  - ALU sub P_hi' - |B|.
  - If ovf or ~ltu: P_hi = ALU_Result and quotient bit 1. Else P_hi unchanged and bit 0.
  - Quotient bit enters P_lo[0].
- POST_LO:
  - mul ops with negRes: sub 0-P_lo; record loZero = eq.
  - div ops with negRes: sub 0-P_lo.
  - Otherwise: add P_lo+0.
- POST_HI:
  - mul ops with negRes: loZero ? sub 0-P_hi : xor P_hi^0xFFFFFFFF.
  - rem ops with negRes: sub 0-P_hi.
  - Otherwise: add P_hi+0.
- Result select: mul -> P_lo; mulh/mulhsu/mulhu -> P_hi; div/divu -> P_lo; rem/remu -> P_hi.
- Overflow 0x80000000 / -1 needs no special case: it yields quotient 0x80000000, remainder 0.
- All state registers update only on the CLK rising edge. ALU outputs are combinational from state.

Optional Feature:
- Macro MCYCLE_ZERO_SKIP_EN.
- Defined: a mul op with Operand1==0 or Operand2==0 skips to DONE; Done at cycle 2, Result=0.
- Undefined: mul ops always take the full 37-cycle flow. The divide-by-zero shortcut is present either way.

Test Plan:
1. mul 0x00000007 x 0xFFFFFFFD -> Result 0xFFFFFFEB; Done exactly at cycle 37; Busy high cycles 1..36.
2. Multiply-high variants:
   - mulh 0x80000000 x 0x80000000 -> 0x40000000.
   - mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - mulhsu 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
3. Divide/remainder:
   - div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF.
   - divu 100/7 -> 14; remu 100/7 -> 2.
4. Divide-by-zero:
   - div 5/0 -> 0xFFFFFFFF, Done at cycle 2; remu 5/0 -> 5.
   - Overflow: div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem same operands -> 0.
5. Start re-pulsed at cycle 5 with different operands -> ignored; original result returned at cycle 37.
6. RESETn low at cycle 10 -> Busy=0, Done=0, Result=0 asynchronously. New op after release completes correctly.
   - With MCYCLE_ZERO_SKIP_EN: mulhu 0 x 0x1234 -> 0 at cycle 2.
